// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: states, opcodes
// and the datapath select encodings also used by the ALU control block.
package mc_pkg;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXE   = 4'd7,
    S_RWB    = 4'd8,
    S_BEQ    = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JMP    = 4'd12,
    S_TRAP   = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_mem_state(state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_mem_timeout.sv
// Memory-access watchdog: counts stalled cycles in a memory state and
// flags expiry on the last allowed stall cycle.
module mc_mem_timeout #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic ready,
  input  logic cnt_en,
  output logic expired
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(MEM_TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_en && !ready) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  // A ready in the limit cycle completes the access instead of expiring.
  assign expired = cnt_en && !ready && (cnt_q == LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multi-cycle MIPS datapath with illegal-op and
// memory-timeout traps; MULTICYCLE_CTRL_PERF_EN adds cycle/retire counters.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic [3:0]  state_o,
  output logic        illegal_op,
  output logic        bus_err
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ret_cnt
`endif
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   bus_err_q, bus_err_d;
  logic   expired;

  mc_mem_timeout #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TO_W       (TO_W)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_d != state_q),
    .ready  (mem_ready),
    .cnt_en (is_mem_state(state_q)),
    .expired(expired)
  );

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    unique case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (mem_ready) begin
          unique case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_MEMRD: state_d = S_MEMWB;
            default: state_d = S_FETCH;
          endcase
        end else if (expired) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        unique case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_REXE;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JMP;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_REXE:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_RWB, S_BEQ, S_ADDIWB, S_JMP: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RST;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    if (!rst) begin
      unique case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          alu_src_b = SRCB_FOUR;
        end
        S_DECODE: alu_src_b = SRCB_IMM_SH2;
        S_MEMADR, S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_REXE: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        S_RWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BEQ: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
        end
        S_ADDIWB: reg_write = 1'b1;
        S_JMP: begin
          pc_write  = 1'b1;
          pc_source = PCSRC_JUMP;
        end
        default: ;
      endcase
    end
  end

  assign state_o    = state_q;
  assign illegal_op = illegal_q;
  assign bus_err    = bus_err_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic        retire;
  logic [31:0] cyc_q, cyc_d, ret_q, ret_d;

  always_comb begin
    retire = (state_q == S_MEMWB) || (state_q == S_RWB) ||
             (state_q == S_BEQ) || (state_q == S_ADDIWB) ||
             (state_q == S_JMP) || ((state_q == S_MEMWR) && mem_ready);
    cyc_d = cyc_q;
    ret_d = ret_q;
    if (state_q != S_TRAP) begin
      cyc_d = cyc_q + 32'd1;
      if (retire) ret_d = ret_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end

  assign cyc_cnt = cyc_q;
  assign ret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomised instruction-level check of multicycle_ctrl against expected
// per-cycle state traces built from instruction latencies and stall plans.
module tb_multicycle_ctrl;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic        ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, pc_source;
  logic [2:0]  alu_op;
  logic [3:0]  state_o;
  logic        illegal_op, bus_err;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .TO_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .op           (op),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .i_or_d       (i_or_d),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .pc_source    (pc_source),
    .state_o      (state_o),
    .illegal_op   (illegal_op),
    .bus_err      (bus_err)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .cyc_cnt      (cyc_cnt),
    .ret_cnt      (ret_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int   st;
    logic rdy;
    logic ill;
    logic be;
  } step_t;

  step_t plan[$];
  int    n_checks = 0;
  int    n_errors = 0;
  logic  bld_ill, bld_be;
  int    n_ret, n_cyc;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {pcw,pcwc,iord,mrd,mwr,irw,rdst,m2r,rwr, srca, srcb[2], aluop[3], pcsrc[2]}
  function automatic logic [16:0] exp_ctl(input int st, input logic rdy);
    case (st)
      1:  return {rdy, 4'b0010, rdy, 3'b000, 1'b0, 2'b01, 3'b000, 2'b00};
      2:  return {9'b000000000, 1'b0, 2'b11, 3'b000, 2'b00};
      3:  return {9'b000000000, 1'b1, 2'b10, 3'b000, 2'b00};
      4:  return {9'b001100000, 8'b0};
      5:  return {9'b000000011, 8'b0};
      6:  return {9'b001010000, 8'b0};
      7:  return {9'b000000000, 1'b1, 2'b00, 3'b010, 2'b00};
      8:  return {9'b000000101, 8'b0};
      9:  return {9'b010000000, 1'b1, 2'b00, 3'b001, 2'b01};
      10: return {9'b000000000, 1'b1, 2'b10, 3'b000, 2'b00};
      11: return {9'b000000001, 8'b0};
      12: return {9'b100000000, 1'b0, 2'b00, 3'b000, 2'b10};
      default: return 17'd0;
    endcase
  endfunction

  function automatic logic [16:0] obs_ctl();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
            reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
            pc_source};
  endfunction

  task automatic push(input int st, input logic rdy);
    step_t e;
    e.st = st; e.rdy = rdy; e.ill = bld_ill; e.be = bld_be;
    plan.push_back(e);
  endtask

  task automatic push_trap();
    for (int i = 0; i < 4; i++) push(13, 1'($urandom_range(0, 1)));
  endtask

  // Memory access stalled k cycles; k >= TO never completes.
  task automatic push_mem(input int st, input int k, output bit trapped);
    trapped = 0;
    if (k >= TO) begin
      for (int i = 0; i < TO; i++) push(st, 1'b0);
      bld_be = 1'b1;
      push_trap();
      trapped = 1;
    end else begin
      for (int i = 0; i < k; i++) push(st, 1'b0);
      push(st, 1'b1);
    end
  endtask

  task automatic step(input step_t e);
    mem_ready = e.rdy;
    #1;
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("cyc_cnt", cyc_cnt, 32'(n_cyc));
    chk("ret_cnt", ret_cnt, 32'(n_ret));
`endif
    chk("state", 32'(state_o), 32'(e.st));
    chk("ctl", 32'(obs_ctl()), 32'(exp_ctl(e.st, e.rdy)));
    chk("illegal_op", 32'(illegal_op), 32'(e.ill));
    chk("bus_err", 32'(bus_err), 32'(e.be));
    if (e.st != 13) n_cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    step_t e;
    rst = 1'b1;
    mem_ready = 1'($urandom_range(0, 1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_ctl", 32'(obs_ctl()), 32'd0);
    chk("rst_flags", {30'd0, illegal_op, bus_err}, 32'd0);
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("rst_cyc", cyc_cnt, 32'd0);
    chk("rst_ret", ret_cnt, 32'd0);
`endif
    rst = 1'b0;
    n_ret = 0; n_cyc = 0;
    bld_ill = 1'b0; bld_be = 1'b0;
    e.st = 0; e.rdy = 1'($urandom_range(0, 1)); e.ill = 1'b0; e.be = 1'b0;
    step(e);
  endtask

  function automatic logic [5:0] op_of(input int kind);
    logic [5:0] o;
    case (kind)
      0: return 6'b000000;
      1: return 6'b100011;
      2: return 6'b101011;
      3: return 6'b000100;
      4: return 6'b001000;
      5: return 6'b000010;
      default: begin
        do o = 6'($urandom);
        while (o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                         6'b001000, 6'b000010});
        return o;
      end
    endcase
  endfunction

  // kind: 0 R, 1 lw, 2 sw, 3 beq, 4 addi, 5 j, 6 illegal
  task automatic run_instr(input int kind, input int kf, input int km);
    bit trapped;
    op = op_of(kind);
    push_mem(1, kf, trapped);
    if (!trapped) begin
      push(2, 1'($urandom_range(0, 1)));
      case (kind)
        0: begin push(7, 1'($urandom_range(0, 1))); push(8, 1'b1); end
        1: begin
          push(3, 1'($urandom_range(0, 1)));
          push_mem(4, km, trapped);
          if (!trapped) push(5, 1'($urandom_range(0, 1)));
        end
        2: begin
          push(3, 1'($urandom_range(0, 1)));
          push_mem(6, km, trapped);
        end
        3: push(9, 1'($urandom_range(0, 1)));
        4: begin push(10, 1'b0); push(11, 1'($urandom_range(0, 1))); end
        5: push(12, 1'($urandom_range(0, 1)));
        default: begin
          bld_ill = 1'b1;
          push_trap();
          trapped = 1;
        end
      endcase
    end
    while (plan.size() > 0) step(plan.pop_front());
    if (trapped) do_reset();
    else n_ret++;
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b1;
    op = 6'd0;
    do_reset();
    run_instr(0, 0, 0);
    run_instr(1, 0, 3);
    run_instr(2, 1, 2);
    run_instr(3, 0, 0);
    run_instr(5, 0, 0);
    run_instr(4, 0, 0);
    run_instr(6, 0, 0);
    run_instr(0, TO - 1, 0);
    run_instr(0, TO, 0);
    run_instr(1, 0, TO - 1);
    run_instr(1, 0, TO);
    run_instr(2, 0, TO);
    for (int n = 0; n < 80; n++) begin
      int kind, kf, km;
      kind = ($urandom_range(0, 19) == 0) ? 6 : int'($urandom_range(0, 5));
      kf = ($urandom_range(0, 24) == 0) ? TO : int'($urandom_range(0, 4));
      km = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO - 1, TO + 1))
                                       : int'($urandom_range(0, 4));
      run_instr(kind, kf, km);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore FSM that sequences a multi-cycle version of the team's MIPS datapath (PC, instruction/data memory, register bank, ALU, sign-extend, branch/jump adders).
- Replaces the single-cycle decoder: one instruction takes 3–5 states, and memory accesses stall on a ready handshake.
- Supported instructions: R-type, lw, sw, beq, addi, j.
- Also provides illegal-opcode and memory-timeout traps.

Parameters:
- MEM_TIMEOUT, 15, maximum number of cycles a memory state waits for mem_ready before trapping (1..255).
- TO_W, 8, width of the timeout counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- op  input  6  instruction[31:26] from the instruction register.
- mem_ready  input  1  memory completed the current access this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if ALU zero flag is set (beq).
- i_or_d  output  1  memory address source: 0 = PC, 1 = ALU result register.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  instruction register load.
- reg_dst  output  1  write address: 0 = rt, 1 = rd.
- mem_to_reg  output  1  write-back data: 0 = ALU, 1 = memory data register.
- reg_write  output  1  register bank write enable.
- alu_src_a  output  1  0 = PC, 1 = register A.
- alu_src_b  output  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_op  output  3  000 = add, 001 = sub, 010 = decode funct.
- pc_source  output  2  00 = ALU, 01 = ALUOut (branch target), 10 = jump target.
- state_o  output  4  current state encoding, for debug.
- illegal_op  output  1  sticky: an unknown opcode was decoded.
- bus_err  output  1  sticky: a memory access timed out.

Behaviour:
- State encoding: RST=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, REXE=7, RWB=8, BEQ=9, ADDIEX=10, ADDIWB=11, JMP=12, TRAP=13.
- Reset:
  - While rst is high, state stays RST, all outputs are 0, and the timeout counter is cleared.
  - Reset has priority over every transition, including mid-access and from TRAP.
  - The first edge with rst low moves the FSM to FETCH.
- Outputs are decoded from the state only (Moore). Any output not listed for a state is 0.
- FETCH:
  - Drives i_or_d=0, mem_read=1, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00.
  - pc_write and ir_write are asserted only in the cycle where mem_ready=1; advance to DECODE on that same edge.
  - Without mem_ready, stay in FETCH with no PC or IR update.
- DECODE: drives alu_src_a=0, alu_src_b=11, alu_op=000. Next state by op:
  - 100011 or 101011 → MEMADR
  - 000000 → REXE
  - 000100 → BEQ
  - 001000 → ADDIEX
  - 000010 → JMP
  - anything else → TRAP with illegal_op set
- MEMADR: drives alu_src_a=1, alu_src_b=10, alu_op=000. Next state: lw → MEMRD, sw → MEMWR.
- MEMRD: drives mem_read=1, i_or_d=1. Waits for mem_ready, then → MEMWB.
- MEMWR: drives mem_write=1, i_or_d=1. Waits for mem_ready, then → FETCH.
- MEMWB: drives reg_write=1, mem_to_reg=1, reg_dst=0. Then → FETCH.
- REXE: drives alu_src_a=1, alu_src_b=00, alu_op=010. Then → RWB.
- RWB: drives reg_write=1, reg_dst=1, mem_to_reg=0. Then → FETCH.
- BEQ: drives alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01. Then → FETCH.
- ADDIEX: drives alu_src_a=1, alu_src_b=10, alu_op=000. Then → ADDIWB.
- ADDIWB: drives reg_write=1, reg_dst=0, mem_to_reg=0. Then → FETCH.
- JMP: drives pc_write=1, pc_source=10. Then → FETCH.
- Memory timeout (FETCH, MEMRD, MEMWR):
  - The timeout counter clears on entry to the state and increments each cycle mem_ready is 0.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0, go to TRAP and set bus_err.
  - If mem_ready=1 in the same cycle the count reaches the limit, the access completes normally; mem_ready wins.
- TRAP: absorbing state. All strobes are 0 and the sticky flags hold; only rst exits it.
- Instruction latency with mem_ready tied high: lw 5 cycles; sw, R-type, addi 4; beq, j 3.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- When defined, adds two outputs:
  - cyc_cnt[31:0]: increments every cycle rst is low.
  - ret_cnt[31:0]: increments on each retire edge — the edge leaving MEMWB, MEMWR (with mem_ready), RWB, BEQ, ADDIWB or JMP.
  - Both counters clear on rst, wrap modulo 2^32, and freeze in TRAP.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package mc_pkg holds:
  - the state enum
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - the alu_op, alu_src_b and pc_source encodings (the ALU control block imports the same alu_op encoding)
- One sub-module, mc_mem_timeout: the timeout counter, with inputs clear, ready and count-enable and output expired.

Test Plan:
- rst high for 3 cycles with mem_ready=1 → state_o=0 and all outputs 0. Release → state_o=1, then 2 one cycle later.
- R-type (op=000000), mem_ready=1 → states 1,2,7,8,1. reg_write=1 and reg_dst=1 only in RWB. 4-cycle latency.
- lw (op=100011), mem_ready low 3 cycles in MEMRD → MEMRD held 4 cycles with mem_read=1, then MEMWB with reg_write=1 and mem_to_reg=1.
- beq / j → BEQ asserts pc_write_cond=1, pc_source=01. JMP asserts pc_write=1, pc_source=10. Each instruction takes 3 cycles.
- op=111111 → DECODE→TRAP, illegal_op=1 and held; mem_ready toggling has no effect; rst clears it.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=15 → TRAP after 15 stalled cycles, bus_err=1. Repeat with mem_ready=1 on cycle 15 → DECODE, no bus_err.
